// File: rtl/spi_slave_adc_mux.sv
// SPI-mode-3 slave emulating a serial ADC: one zero-padded sample per cs_n frame,
// channel address captured from MOSI and applied to the following frame.
module spi_slave_adc_mux #(
  parameter int DATA_W     = 12,
  parameter int CHANNELS   = 8,
  parameter int ADDR_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  parameter int LEAD_ZEROS = 4,
  parameter int FRAME_LEN  = 16,
  parameter int ADDR_POS   = 2
) (
  input  logic                       n_rst,
  input  logic                       sclk,
  input  logic                       cs_n,
  input  logic                       mosi,
  input  logic [CHANNELS*DATA_W-1:0] data,
  output logic                       sdata,
  output logic                       sdata_oe,
  output logic [ADDR_W-1:0]          ch_cur,
  output logic                       frame_done
);

  localparam int CW = $clog2(FRAME_LEN + 1);
  localparam logic [CW-1:0] LAST = CW'(FRAME_LEN - 1);
  localparam logic [CW-1:0] FULL = CW'(FRAME_LEN);
  localparam logic [CW-1:0] LOAD = CW'(LEAD_ZEROS - 1);
  localparam logic [CW-1:0] D_LO = CW'(LEAD_ZEROS);
  localparam logic [CW-1:0] D_HI = CW'(LEAD_ZEROS + DATA_W);
  localparam logic [CW-1:0] A_LO = CW'(ADDR_POS + 1);
  localparam logic [CW-1:0] A_HI = CW'(ADDR_POS + ADDR_W);

  logic [CW-1:0]     cnt;
  logic [DATA_W-1:0] dsh;
  logic [DATA_W-1:0] sel;
  logic [ADDR_W-1:0] ash;
  logic              lock;
  logic              frst_n;

  // A reset that lands inside a frame blocks the bus until cs_n is released,
  // so the frame cannot silently restart mid-word when n_rst deasserts.
  always_ff @(negedge n_rst or posedge cs_n) begin
    if (cs_n) lock <= 1'b0;
    else      lock <= 1'b1;
  end

  assign frst_n   = n_rst & ~cs_n & ~lock;
  assign sdata_oe = frst_n & (cnt < FULL);
  assign sdata    = sdata_oe ? ((cnt >= D_LO && cnt < D_HI) ? dsh[DATA_W-1] : 1'b0) : 1'bz;

  always_comb begin
    sel = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (ch_cur == ADDR_W'(c)) sel = data[c*DATA_W +: DATA_W];
    end
  end

  always_ff @(negedge sclk or negedge frst_n) begin
    if (!frst_n) begin
      cnt        <= '0;
      dsh        <= '0;
      frame_done <= 1'b0;
    end else begin
      if (cnt < FULL) cnt <= cnt + 1'b1;
      if (cnt == LOAD)       dsh <= sel;
      else if (cnt >= D_LO)  dsh <= dsh << 1;
      if (cnt == LAST) frame_done <= 1'b1;
    end
  end

  // Rising edge following falling edge r carries MOSI frame bit r-1.
  always_ff @(posedge sclk or negedge frst_n) begin
    if (!frst_n)                       ash <= '0;
    else if (cnt >= A_LO && cnt <= A_HI) ash <= ADDR_W'({ash, mosi});
  end

  always_ff @(negedge sclk or negedge n_rst) begin
    if (!n_rst)                        ch_cur <= '0;
    else if (frst_n && cnt == LAST)    ch_cur <= ash;
  end

endmodule

// File: tb/tb_spi_slave_adc_mux.sv
// Directed + randomized frames against a word-level ADC model (sample framed by
// leading zeros, address applied one frame later).
`timescale 1ns/1ps
module tb_spi_slave_adc_mux;
  localparam int LZ = 4;
  localparam int DW = 12;
  localparam int FL = 16;
  localparam int CH = 8;

  logic          n_rst, sclk, cs_n, mosi;
  logic [CH*DW-1:0] data;
  wire           sdata;
  logic          sdata_oe;
  logic [2:0]    ch_cur;
  logic          frame_done;

  int         pass_cnt = 0;
  int         total = 0;
  int         model_ch = 0;
  logic [11:0] vals [CH];

  spi_slave_adc_mux dut (
    .n_rst(n_rst), .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .data(data),
    .sdata(sdata), .sdata_oe(sdata_oe), .ch_cur(ch_cur), .frame_done(frame_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic drive_data();
    for (int c = 0; c < CH; c++) data[c*DW +: DW] = vals[c];
  endtask

  task automatic tick();
    #5 sclk = 1'b0;
    #5 sclk = 1'b1;
    #5;
  endtask

  // One frame; abort_at>0 raises cs_n after that many clocks.
  task automatic run_frame(input logic [15:0] mw, input int nclk, input int abort_at,
                           input int chg_at, input logic [11:0] chg_val);
    int nc;
    logic [11:0] samp;
    logic [15:0] expw, got;
    nc   = (abort_at > 0) ? abort_at : nclk;
    samp = '0;
    expw = '0;
    got  = '0;
    mosi = mw[15];
    cs_n = 1'b0;
    #1;
    chk("oe_at_cs_fall", 32'(sdata_oe), 32'd1);
    chk("bit0", 32'(sdata), 32'd0);
    got[15] = sdata;
    #4;
    for (int k = 1; k <= nc; k++) begin
      mosi = (k <= 16) ? mw[16-k] : 1'b0;
      #5 sclk = 1'b0;
      if (k == LZ) begin
        samp = vals[model_ch];
        expw = 16'(samp) << (FL - LZ - DW);
      end
      #1;
      if (k < FL) begin
        chk("oe_bit", 32'(sdata_oe), 32'd1);
        chk("bit", 32'(sdata), 32'(expw[15-k]));
        got[15-k] = sdata;
      end else begin
        chk("z_after_frame", 32'(sdata_oe), 32'd0);
      end
      if (k == chg_at) begin
        vals[0] = chg_val;
        drive_data();
      end
      #4 sclk = 1'b1;
      #5;
    end
    if (nc >= FL) begin
      chk("word", 32'(got), 32'(expw));
      model_ch = int'(mw[13:11]);
      chk("frame_done", 32'(frame_done), 32'd1);
      chk("ch_update", 32'(ch_cur), 32'(model_ch));
      if (nc > FL) chk("cnt_hold", 32'(dut.cnt), 32'(FL));
    end else begin
      chk("done_abort", 32'(frame_done), 32'd0);
      chk("ch_abort", 32'(ch_cur), 32'(model_ch));
    end
    cs_n = 1'b1;
    #1;
    chk("z_cs_high", 32'(sdata_oe), 32'd0);
    chk("done_clear", 32'(frame_done), 32'd0);
    #4;
  endtask

  initial begin
    n_rst = 1'b1; cs_n = 1'b1; sclk = 1'b1; mosi = 1'b0;
    for (int c = 0; c < CH; c++) vals[c] = 12'(12'h100 + c);
    drive_data();
    #2 n_rst = 1'b0;
    #1;
    chk("rst_oe", 32'(sdata_oe), 32'd0);
    chk("rst_ch", 32'(ch_cur), 32'd0);
    chk("rst_done", 32'(frame_done), 32'd0);
    cs_n = 1'b0;
    tick();
    chk("rst_oe_cs_low", 32'(sdata_oe), 32'd0);
    cs_n = 1'b1;
    #5 n_rst = 1'b1;
    #5;

    run_frame(16'h0000, 16, 0, 0, 12'h0);
    run_frame(16'h2800, 16, 0, 0, 12'h0);
    run_frame(16'h0000, 16, 0, 0, 12'h0);
    run_frame(16'h1800, 16, 10, 0, 12'h0);
    run_frame(16'h0000, 16, 0, 0, 12'h0);
    run_frame(16'h2800, 20, 0, 0, 12'h0);

    // n_rst pulse at clock 8 of a frame with addr 5 pending
    mosi = 1'b0;
    cs_n = 1'b0;
    #5;
    for (int k = 0; k < 8; k++) tick();
    n_rst = 1'b0;
    model_ch = 0;
    #1;
    chk("mid_rst_oe", 32'(sdata_oe), 32'd0);
    chk("mid_rst_ch", 32'(ch_cur), 32'd0);
    #2 n_rst = 1'b1;
    #2;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("no_resume", 32'(sdata_oe), 32'd0);
    end
    cs_n = 1'b1;
    #5;
    run_frame(16'h0000, 16, 0, 0, 12'h0);

    run_frame(16'h0000, 16, 0, 4, 12'hABC);
    run_frame(16'h0000, 16, 0, 0, 12'h0);

    for (int f = 0; f < 12; f++) begin
      for (int c = 0; c < CH; c++) vals[c] = 12'($urandom);
      drive_data();
      run_frame(16'($urandom), $urandom_range(16, 19),
                ($urandom_range(0, 4) == 0) ? $urandom_range(1, 15) : 0, 0, 12'h0);
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
